// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SD block responder.
package sd_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_FETCH,
    RD_PUT,
    WR_ADDR,
    WR_STORE,
    DONE
  } state_e;

  localparam int SECTOR_BYTES = 512;
  localparam int IDX_W = 9;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(SECTOR_BYTES - 1);

  function automatic logic [63:0] lba_bytes(
    input logic [31:0] lba
  );
    return {23'd0, lba, 9'd0};
  endfunction

endpackage

// File: rtl/sd_resp_mount.sv
// Per-drive image size / read-only tables and
// the img_* mount notification outputs.
module sd_resp_mount
  import sd_resp_pkg::*;
#(
  parameter int NDRIVES = 2
) (
  input  logic                       CLK_VIDEO,
  input  logic                       reset,
  input  logic [NDRIVES-1:0]         mount_req_i,
  input  logic [63:0]                mount_size_i,
  input  logic                       mount_ro_i,
  output logic [NDRIVES-1:0][63:0]   size_o,
  output logic [NDRIVES-1:0]         ro_o,
  output logic [NDRIVES-1:0]         img_mounted_o,
  output logic [63:0]                img_size_o,
  output logic                       img_readonly_o
);

  logic [NDRIVES-1:0][63:0] size_q;
  logic [NDRIVES-1:0]       ro_q;
  logic [NDRIVES-1:0]       mnt_q;
  logic [63:0]              isz_q;
  logic                     iro_q;

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      size_q <= '0;
      ro_q   <= '0;
      mnt_q  <= '0;
      isz_q  <= '0;
      iro_q  <= 1'b0;
    end else begin
      mnt_q <= mount_req_i;
      // descending walk so the lowest index lands last
      for (int i = NDRIVES - 1; i >= 0; i--) begin
        if (mount_req_i[i]) begin
          size_q[i] <= mount_size_i;
          ro_q[i]   <= mount_ro_i;
          isz_q     <= mount_size_i;
          iro_q     <= mount_ro_i;
        end
      end
    end
  end

  assign size_o         = size_q;
  assign ro_o           = ro_q;
  assign img_mounted_o  = mnt_q;
  assign img_size_o     = isz_q;
  assign img_readonly_o = iro_q;

endmodule

// File: rtl/sd_block_responder.sv
// Host-side sector responder: arbitrates drive requests
// and streams 512-byte sectors between core and image memory.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int NDRIVES = 2,
  parameter int DIN_LAT = 2,
  parameter int GAP     = 2,
  localparam int DW = (NDRIVES > 1) ? $clog2(NDRIVES) : 1
) (
  input  logic                   CLK_VIDEO,
  input  logic                   reset,
  input  logic [32*NDRIVES-1:0]  sd_lba,
  input  logic [NDRIVES-1:0]     sd_rd,
  input  logic [NDRIVES-1:0]     sd_wr,
  output logic [NDRIVES-1:0]     sd_ack,
  output logic [IDX_W-1:0]       sd_buff_addr,
  output logic [7:0]             sd_buff_dout,
  output logic                   sd_buff_wr,
  input  logic [8*NDRIVES-1:0]   sd_buff_din,
  input  logic [NDRIVES-1:0]     mount_req,
  input  logic [63:0]            mount_size,
  input  logic                   mount_ro,
  output logic [NDRIVES-1:0]     img_mounted,
  output logic [63:0]            img_size,
  output logic                   img_readonly,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [DW-1:0]          mem_drive,
  output logic [31:0]            mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic                   mem_ready,
  input  logic [7:0]             mem_rdata
);

  logic [NDRIVES-1:0][63:0] size_w;
  logic [NDRIVES-1:0]       ro_w;

  sd_resp_mount #(.NDRIVES(NDRIVES)) u_mount (
    .CLK_VIDEO      (CLK_VIDEO),
    .reset          (reset),
    .mount_req_i    (mount_req),
    .mount_size_i   (mount_size),
    .mount_ro_i     (mount_ro),
    .size_o         (size_w),
    .ro_o           (ro_w),
    .img_mounted_o  (img_mounted),
    .img_size_o     (img_size),
    .img_readonly_o (img_readonly)
  );

  state_e             state_q;
  logic [NDRIVES-1:0] ack_q;
  logic [DW-1:0]      drv_q;
  logic               wr_q;
  logic [22:0]        lba_q;
  logic               oob_q;
  logic               ro_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   addr_q;
  logic [7:0]         dout_q;
  logic               bwr_q;
  logic               req_q;
  logic               we_q;
  logic [7:0]         wdat_q;
  logic [7:0]         cnt_q;

  logic               hit;
  logic [DW-1:0]      sel;
  logic               sel_wr;
  logic [31:0]        sel_lba;
  logic [63:0]        sel_size;
  logic               sel_ro;
  logic [7:0]         din_sel;

  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    sel_wr   = 1'b0;
    sel_lba  = '0;
    sel_size = '0;
    sel_ro   = 1'b0;
    for (int i = NDRIVES - 1; i >= 0; i--) begin
      if (sd_rd[i] | sd_wr[i]) begin
        hit      = 1'b1;
        sel      = DW'(i);
        sel_wr   = !sd_rd[i];
        sel_lba  = sd_lba[32*i +: 32];
        sel_size = size_w[i];
        sel_ro   = ro_w[i];
      end
    end
  end

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NDRIVES; i++) begin
      if (drv_q == DW'(i)) din_sel = sd_buff_din[8*i +: 8];
    end
  end

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      drv_q   <= '0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      oob_q   <= 1'b0;
      ro_q    <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      bwr_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= ACK;
            ack_q   <= NDRIVES'(1) << sel;
            drv_q   <= sel;
            wr_q    <= sel_wr;
            lba_q   <= sel_lba[22:0];
            oob_q   <= lba_bytes(sel_lba) >= sel_size;
            ro_q    <= sel_ro;
            idx_q   <= '0;
          end
        end
        ACK: begin
          cnt_q <= '0;
          if (wr_q) begin
            state_q <= WR_ADDR;
            addr_q  <= idx_q;
          end else begin
            state_q <= RD_FETCH;
            req_q   <= !oob_q;
            we_q    <= 1'b0;
          end
        end
        RD_FETCH: begin
          if (oob_q || mem_ready) begin
            req_q   <= 1'b0;
            dout_q  <= oob_q ? 8'h00 : mem_rdata;
            addr_q  <= idx_q;
            bwr_q   <= 1'b1;
            state_q <= RD_PUT;
          end
        end
        RD_PUT: begin
          bwr_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            ack_q   <= '0;
            cnt_q   <= '0;
          end else begin
            idx_q   <= idx_d;
            req_q   <= !oob_q;
            state_q <= RD_FETCH;
          end
        end
        WR_ADDR: begin
          if (cnt_q == 8'(DIN_LAT - 1)) begin
            wdat_q  <= din_sel;
            req_q   <= !(oob_q || ro_q);
            we_q    <= 1'b1;
            state_q <= WR_STORE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WR_STORE: begin
          // skipped stores fall straight through
          if (!req_q || mem_ready) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              ack_q   <= '0;
            end else begin
              idx_q   <= idx_d;
              addr_q  <= idx_d;
              state_q <= WR_ADDR;
            end
          end
        end
        DONE: begin
          if (cnt_q == 8'(GAP - 1)) state_q <= IDLE;
          else cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = addr_q;
  assign sd_buff_dout = dout_q;
  assign sd_buff_wr   = bwr_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_drive    = drv_q;
  assign mem_addr     = {lba_q, idx_q};
  assign mem_wdata    = wdat_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with a
// latency-programmable image memory and registered core buffer.
module tb_sd_block_responder;

  logic        CLK_VIDEO = 1'b0;
  logic        reset;
  logic [63:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;
  logic [1:0]  mount_req;
  logic [63:0] mount_size;
  logic        mount_ro;
  logic [1:0]  img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        mem_req, mem_we, mem_ready;
  logic [0:0]  mem_drive;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  sd_block_responder #(
    .NDRIVES(2), .DIN_LAT(2), .GAP(2)
  ) dut (
    .CLK_VIDEO    (CLK_VIDEO),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .mount_req    (mount_req),
    .mount_size   (mount_size),
    .mount_ro     (mount_ro),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_drive    (mem_drive),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  int         lat = 0;
  logic [3:0] wcnt = '0;
  logic [7:0] buf_q = '0;

  always @(posedge CLK_VIDEO) begin
    wcnt  <= (mem_req && !mem_ready) ? wcnt + 4'd1 : 4'd0;
    buf_q <= ~sd_buff_addr[7:0];
  end

  assign mem_ready   = mem_req && (int'(wcnt) >= lat);
  assign mem_rdata   = mem_addr[7:0];
  assign sd_buff_din = {buf_q, 8'h5A};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         strobes, reads, writes, reqcyc;
  int         bad, lba_bad, gap_bad, rises, low_cnt = 100;
  logic [8:0] exp_idx;
  logic [22:0] exp_lba;
  logic       oob_mode = 1'b0;
  logic       ack_prev = 1'b0;

  always @(negedge CLK_VIDEO) begin
    if (sd_buff_wr) begin
      strobes++;
      if (sd_buff_addr !== exp_idx) bad++;
      if (sd_buff_dout !== (oob_mode ? 8'h00 : exp_idx[7:0])) bad++;
      if (sd_ack == 2'b00) bad++;
      exp_idx = exp_idx + 9'd1;
    end
    if (mem_req) reqcyc++;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        writes++;
        if (mem_wdata !== ~mem_addr[7:0]) bad++;
      end else begin
        reads++;
      end
      if (mem_addr[31:9] !== exp_lba) lba_bad++;
      if (mem_drive[0] !== sd_ack[1]) bad++;
    end
    if ((|sd_ack) && !ack_prev) begin
      rises++;
      if (low_cnt < 2) gap_bad++;
    end
    if (|sd_ack) low_cnt = 0;
    else low_cnt++;
    if ($countones(sd_ack) > 1) bad++;
    ack_prev = |sd_ack;
  end

  task automatic clr();
    @(posedge CLK_VIDEO);
    #1;
    strobes = 0; reads = 0; writes = 0; reqcyc = 0;
    bad = 0; lba_bad = 0; gap_bad = 0; rises = 0;
    exp_idx = '0;
  endtask

  task automatic wait_ack(input logic lvl,
                          input int budget,
                          input string tag);
    int n = 0;
    while (((|sd_ack) != lvl) && n < budget) begin
      @(negedge CLK_VIDEO);
      n++;
    end
    chk({tag, "_wait"}, 64'(n < budget), 64'd1);
  endtask

  task automatic mount(input logic [1:0] m,
                       input logic [63:0] sz,
                       input logic ro);
    @(negedge CLK_VIDEO);
    mount_req = m; mount_size = sz; mount_ro = ro;
    @(negedge CLK_VIDEO);
    mount_req = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_VIDEO);
  endtask

  initial begin
    reset = 1'b1; sd_lba = '0; sd_rd = '0; sd_wr = '0;
    mount_req = '0; mount_size = '0; mount_ro = 1'b0;
    exp_lba = '0; exp_idx = '0;
    idle(3);
    chk("rst_ack", 64'(sd_ack), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_bwr", 64'(sd_buff_wr), 64'd0);
    chk("rst_mnt", 64'(img_mounted), 64'd0);
    chk("rst_size", img_size, 64'd0);
    chk("rst_addr", 64'(sd_buff_addr), 64'd0);
    reset = 1'b0;
    idle(2);

    mount(2'b11, 64'h1_0000_0000, 1'b0);
    @(negedge CLK_VIDEO);
    mount_req = 2'b10; mount_size = 64'd143360; mount_ro = 1'b0;
    @(negedge CLK_VIDEO);
    mount_req = 2'b00;
    chk("mnt_pulse", 64'(img_mounted), 64'h2);
    chk("mnt_size", img_size, 64'd143360);
    @(negedge CLK_VIDEO);
    chk("mnt_pulse_end", 64'(img_mounted), 64'h0);
    chk("mnt_ro", 64'(img_readonly), 64'd0);

    // single sector read, drive 0
    clr(); lat = 0; oob_mode = 1'b0; exp_lba = 23'd5;
    sd_lba[31:0] = 32'd5; sd_rd = 2'b01;
    wait_ack(1'b1, 50, "rd_rise");
    sd_rd = 2'b00;
    wait_ack(1'b0, 5000, "rd_fall");
    idle(6);
    chk("rd_strobes", 64'(strobes), 64'd512);
    chk("rd_reads", 64'(reads), 64'd512);
    chk("rd_bad", 64'(bad), 64'd0);
    chk("rd_lba", 64'(lba_bad), 64'd0);
    chk("rd_rises", 64'(rises), 64'd1);

    // 13-sector track read, lba bumped on each ack rise
    clr(); sd_lba[31:0] = 32'd39; sd_rd = 2'b01;
    for (int k = 0; k < 13; k++) begin
      wait_ack(1'b1, 50, "trk_rise");
      exp_lba = sd_lba[22:0];
      if (k == 12) sd_rd = 2'b00;
      else sd_lba[31:0] = sd_lba[31:0] + 32'd1;
      wait_ack(1'b0, 5000, "trk_fall");
    end
    idle(6);
    chk("trk_rises", 64'(rises), 64'd13);
    chk("trk_strobes", 64'(strobes), 64'd6656);
    chk("trk_gap", 64'(gap_bad), 64'd0);
    chk("trk_lba", 64'(lba_bad), 64'd0);
    chk("trk_bad", 64'(bad), 64'd0);
    chk("trk_last_lba", 64'(exp_lba), 64'd51);

    // write on drive 1
    clr(); exp_lba = 23'd3;
    sd_lba[63:32] = 32'd3; sd_wr = 2'b10;
    wait_ack(1'b1, 50, "wr_rise");
    sd_wr = 2'b00;
    wait_ack(1'b0, 8000, "wr_fall");
    idle(6);
    chk("wr_writes", 64'(writes), 64'd512);
    chk("wr_reads", 64'(reads), 64'd0);
    chk("wr_strobes", 64'(strobes), 64'd0);
    chk("wr_bad", 64'(bad), 64'd0);
    chk("wr_lba", 64'(lba_bad), 64'd0);

    // read-only image: handshake completes, no memory traffic
    mount(2'b10, 64'd143360, 1'b1);
    chk("ro_flag", 64'(img_readonly), 64'd1);
    clr(); sd_wr = 2'b10;
    wait_ack(1'b1, 50, "ro_rise");
    sd_wr = 2'b00;
    wait_ack(1'b0, 8000, "ro_fall");
    idle(6);
    chk("ro_reqcyc", 64'(reqcyc), 64'd0);
    chk("ro_rises", 64'(rises), 64'd1);

    // out-of-bounds read
    mount(2'b01, 64'd1024, 1'b0);
    clr(); oob_mode = 1'b1;
    sd_lba[31:0] = 32'd2; sd_rd = 2'b01;
    wait_ack(1'b1, 50, "oob_rise");
    sd_rd = 2'b00;
    wait_ack(1'b0, 5000, "oob_fall");
    idle(6);
    chk("oob_strobes", 64'(strobes), 64'd512);
    chk("oob_reqcyc", 64'(reqcyc), 64'd0);
    chk("oob_bad", 64'(bad), 64'd0);

    // both drives at once, stalled memory
    mount(2'b11, 64'h1_0000_0000, 1'b0);
    clr(); oob_mode = 1'b0; lat = 5;
    sd_lba = {32'd9, 32'd7}; sd_rd = 2'b11;
    wait_ack(1'b1, 50, "dual_rise0");
    chk("dual_first", 64'(sd_ack), 64'h1);
    exp_lba = 23'd7; sd_rd = 2'b10;
    wait_ack(1'b0, 8000, "dual_fall0");
    wait_ack(1'b1, 50, "dual_rise1");
    chk("dual_second", 64'(sd_ack), 64'h2);
    exp_lba = 23'd9; sd_rd = 2'b00;
    wait_ack(1'b0, 8000, "dual_fall1");
    idle(6);
    chk("dual_strobes", 64'(strobes), 64'd1024);
    chk("dual_reads", 64'(reads), 64'd1024);
    chk("dual_bad", 64'(bad), 64'd0);
    chk("dual_lba", 64'(lba_bad), 64'd0);
    chk("dual_gap", 64'(gap_bad), 64'd0);

    // reset mid-read
    clr(); lat = 0; exp_lba = 23'd1;
    sd_lba[31:0] = 32'd1; sd_rd = 2'b01;
    begin
      int n = 0;
      while (strobes < 100 && n < 2000) begin
        @(negedge CLK_VIDEO);
        n++;
      end
      chk("mid_reach", 64'(strobes >= 100), 64'd1);
    end
    reset = 1'b1; sd_rd = 2'b00;
    @(negedge CLK_VIDEO);
    chk("mid_ack", 64'(sd_ack), 64'd0);
    chk("mid_req", 64'(mem_req), 64'd0);
    chk("mid_bwr", 64'(sd_buff_wr), 64'd0);
    chk("mid_size", img_size, 64'd0);
    reset = 1'b0;
    idle(5);
    chk("post_ack", 64'(sd_ack), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
